// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: captures Y/OFlags, commits masked flags into SR,
// buffers results in a 2-entry FIFO toward writeback and decodes branch conditions.
module alu_result_stage #(
    parameter int DataWidth = 8,
    parameter int FlagBits  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [DataWidth-1:0] Y,
    input  logic [FlagBits-1:0]  OFlags,
    input  logic [FlagBits-1:0]  FlagMask,
    input  logic                 WrDest,
    input  logic                 FlagWr,
    input  logic [FlagBits-1:0]  FlagWrData,
    output logic [FlagBits-1:0]  SR,
    input  logic [2:0]           Cond,
    output logic                 CondTrue,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [DataWidth-1:0] Out_Data
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends on ready, and In_Ready depends only on the stored count.
    logic [DataWidth-1:0] mem [2];
    logic [1:0]           count;
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [FlagBits-1:0]  sr;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 flag_bit;

    assign accept    = In_Valid & In_Ready;
    assign push      = accept & WrDest;
    assign pop       = Out_Valid & Out_Ready;

    assign In_Ready  = (count != 2'd2);
    assign Out_Valid = (count != 2'd0);
    assign Out_Data  = mem[rd_ptr];
    assign SR        = sr;

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            sr     <= '0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= Y;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
            // A direct flag write wins over the ALU flags for every bit.
            if (FlagWr) begin
                sr <= FlagWrData;
            end else if (accept) begin
                sr <= (sr & ~FlagMask) | (OFlags & FlagMask);
            end
        end
    end

    // Cond[2:1] picks the flag (Z,C,N,V); Cond[0] selects the inverted sense.
    always_comb begin
        flag_bit = 1'b0;
        case (Cond[2:1])
            2'd0:    flag_bit = sr[0];
            2'd1:    flag_bit = sr[1];
            2'd2:    flag_bit = sr[2];
            default: flag_bit = sr[3];
        endcase
        CondTrue = flag_bit ^ Cond[0];
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scenario tasks plus a FIFO scoreboard.
module tb_alu_result_stage;

    localparam int DW = 8;
    localparam int FB = 4;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] y;
    logic [FB-1:0] oflags;
    logic [FB-1:0] flag_mask;
    logic          wr_dest;
    logic          flag_wr;
    logic [FB-1:0] flag_wr_data;
    logic [FB-1:0] sr;
    logic [2:0]    cond;
    logic          cond_true;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    logic [DW-1:0] exp_q[$];
    int            tests_run;
    int            tests_failed;

    alu_result_stage #(.DataWidth(DW), .FlagBits(FB)) dut (
        .Clk(clk), .Reset_N(reset_n), .In_Valid(in_valid), .In_Ready(in_ready),
        .Y(y), .OFlags(oflags), .FlagMask(flag_mask), .WrDest(wr_dest),
        .FlagWr(flag_wr), .FlagWrData(flag_wr_data), .SR(sr), .Cond(cond),
        .CondTrue(cond_true), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Out_Data(out_data)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: the scoreboard records accepts and checks pops against the
    // inputs/outputs settled before the edge, then returns at the falling edge.
    task automatic tick();
        logic [DW-1:0] exp;
        if (reset_n) begin
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_pop: unexpected pop data=%h, queue empty", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        tests_failed++;
                        $display("FAIL scoreboard_pop: got %h expected %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready && wr_dest) exp_q.push_back(y);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; y = '0; oflags = '0; flag_mask = '0; wr_dest = 1'b0;
        flag_wr = 1'b0; flag_wr_data = '0; cond = 3'd0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b1; y = 8'hAA; wr_dest = 1'b1; flag_mask = 4'hF; oflags = 4'hF;
        tick();
        tick();
        idle_inputs();
        reset_n = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || sr !== 4'h0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid=%b sr=%b in_ready=%b out_data=%h expected 0 0000 1 00",
                     out_valid, sr, in_ready, out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || sr !== 4'h0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: out_valid=%b sr=%b in_ready=%b expected 0 0000 1",
                     out_valid, sr, in_ready);
        end
    endtask

    task automatic test_accept();
        in_valid = 1'b1; y = 8'h34; oflags = 4'b0010; flag_mask = 4'hF; wr_dest = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (sr !== 4'b0010 || out_valid !== 1'b1 || out_data !== 8'h34) begin
            tests_failed++;
            $display("FAIL accept: sr=%b out_valid=%b out_data=%h expected 0010 1 34",
                     sr, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; wr_dest = 1'b1; y = 8'h11;
        tick();
        y = 8'h22;
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL backpressure_full: in_ready=%b out_data=%h expected 0 11", in_ready, out_data);
        end
        y = 8'h33;
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL backpressure_hold: in_ready=%b out_valid=%b out_data=%h expected 0 1 11",
                     in_ready, out_valid, out_data);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_data !== 8'h22) begin
            tests_failed++;
            $display("FAIL backpressure_order: in_ready=%b out_data=%h expected 1 22", in_ready, out_data);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_empty: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_mask();
        flag_wr = 1'b1; flag_wr_data = 4'hF;
        tick();
        flag_wr = 1'b0;
        tests_run++;
        if (sr !== 4'hF) begin
            tests_failed++;
            $display("FAIL mask_setup: sr=%b expected 1111", sr);
        end
        in_valid = 1'b1; oflags = 4'h0; flag_mask = 4'b0001; wr_dest = 1'b0; y = 8'h77;
        tick();
        idle_inputs();
        tests_run++;
        if (sr !== 4'b1110 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_compare: sr=%b out_valid=%b expected 1110 0", sr, out_valid);
        end
    endtask

    task automatic test_priority();
        flag_wr = 1'b1; flag_wr_data = 4'b0101;
        in_valid = 1'b1; oflags = 4'b1010; flag_mask = 4'hF; wr_dest = 1'b1; y = 8'h5A;
        tick();
        idle_inputs();
        tests_run++;
        if (sr !== 4'b0101 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL priority: sr=%b out_valid=%b out_data=%h expected 0101 1 5a",
                     sr, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_cond();
        logic [7:0] exp_eq1;
        logic [3:0] s;
        logic       exp;
        // SR=0001: EQ NE CS CC MI PL VS VC -> 1 0 0 1 0 1 0 1 (bit k = cond k)
        exp_eq1 = 8'b1010_1001;
        flag_wr = 1'b1; flag_wr_data = 4'b0001;
        tick();
        flag_wr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cond = c[2:0];
            #1;
            tests_run++;
            if (cond_true !== exp_eq1[c]) begin
                tests_failed++;
                $display("FAIL cond_sr0001[%0d]: got %b expected %b", c, cond_true, exp_eq1[c]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            s = 4'($urandom_range(0, 15));
            flag_wr = 1'b1; flag_wr_data = s;
            tick();
            flag_wr = 1'b0;
            for (int c = 0; c < 8; c++) begin
                cond = c[2:0];
                #1;
                case (c)
                    0: exp = s[0];
                    1: exp = !s[0];
                    2: exp = s[1];
                    3: exp = !s[1];
                    4: exp = s[2];
                    5: exp = !s[2];
                    6: exp = s[3];
                    default: exp = !s[3];
                endcase
                tests_run++;
                if (cond_true !== exp) begin
                    tests_failed++;
                    $display("FAIL cond_rand sr=%b cond=%0d: got %b expected %b", s, c, cond_true, exp);
                end
            end
        end
        cond = 3'd0;
    endtask

    task automatic test_push_pop();
        in_valid = 1'b1; wr_dest = 1'b1; y = 8'hA1;
        tick();
        y = 8'hB2; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hB2 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL push_pop_count1: out_valid=%b out_data=%h in_ready=%b expected 1 b2 1",
                     out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL push_pop_drain: out_valid=%b expected 0", out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] exp_sr;
        flag_wr = 1'b1; flag_wr_data = 4'h0;
        tick();
        exp_sr = 4'h0;
        for (int n = 0; n < 300; n++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            y            = 8'($urandom_range(0, 255));
            oflags       = 4'($urandom_range(0, 15));
            flag_mask    = 4'($urandom_range(0, 15));
            wr_dest      = ($urandom_range(0, 4) != 0);
            flag_wr      = ($urandom_range(0, 9) == 0);
            flag_wr_data = 4'($urandom_range(0, 15));
            #1;
            tests_run++;
            if (in_ready !== (exp_q.size() != 2) || out_valid !== (exp_q.size() != 0) || sr !== exp_sr) begin
                tests_failed++;
                $display("FAIL b2b cycle %0d: in_ready=%b out_valid=%b sr=%b expected %b %b %b", n,
                         in_ready, out_valid, sr, exp_q.size() != 2, exp_q.size() != 0, exp_sr);
            end
            if (flag_wr) exp_sr = flag_wr_data;
            else if (in_valid && exp_q.size() != 2) exp_sr = (exp_sr & ~flag_mask) | (oflags & flag_mask);
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; wr_dest = 1'b1; y = 8'hC3;
        flag_wr = 1'b1; flag_wr_data = 4'hA;
        tick();
        flag_wr = 1'b0; y = 8'hC4;
        tick();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sr !== 4'h0 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b sr=%b out_data=%h expected 0 1 0000 00",
                     out_valid, in_ready, sr, out_data);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_accept();
        test_backpressure();
        test_mask();
        test_priority();
        test_cond();
        test_push_pop();
        test_back_to_back();
        test_mid_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: %0d entries never popped, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
